// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned ZERO_REG = 0;

   // Address width needed to index n registers
   function automatic int unsigned addr_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: flush beats issue, issue beats writeback clear.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned AW   = addr_width(NREG_DEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_iss_en,
   input  logic [AW-1:0]   i_iss_addr,
   input  logic            i_flush,
   input  logic [NREG-1:0] i_clr_vec,
   output logic [NREG-1:0] o_busy_vec
);

   logic [NREG-1:0] r_pend;
   logic [NREG-1:0] w_pend_nxt;

   // Next pending state with flush > issue > clear > hold; register 0 never pending
   always_comb begin
      w_pend_nxt = r_pend;
      for (int unsigned r = 0; r < NREG; r++) begin
         if (i_flush)
            w_pend_nxt[r] = 1'b0;
         else if (i_iss_en && (i_iss_addr == AW'(r)))
            w_pend_nxt[r] = 1'b1;
         else if (i_clr_vec[r])
            w_pend_nxt[r] = 1'b0;
      end
      w_pend_nxt[ZERO_REG] = 1'b0;
   end

   // Pending flops, cleared asynchronously on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pend <= '0;
      else     r_pend <= w_pend_nxt;
   end

   assign o_busy_vec = r_pend;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write bypass and pending scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int unsigned XLEN = XLEN_DEF,
   parameter  int unsigned NREG = NREG_DEF,
   parameter  int unsigned NRD  = 2,
   parameter  int unsigned NWR  = 2,
   localparam int unsigned AW   = addr_width(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [NRD-1:0]       rd_ready,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*AW-1:0]    wr_addr,
   input  logic [NWR*XLEN-1:0]  wr_data,
   input  logic                 iss_en,
   input  logic [AW-1:0]        iss_addr,
   input  logic                 flush,
   output logic [NREG-1:0]      busy_vec
);

   logic [XLEN-1:0] r_rf [NREG];
   logic [NREG-1:0] w_wr_hit;
   logic [XLEN-1:0] w_wr_val [NREG];

   // Per-register write decode; later ports overwrite earlier ones so the highest index wins
   always_comb begin
      w_wr_hit = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         w_wr_val[r] = '0;
         for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
               w_wr_hit[r] = 1'b1;
               w_wr_val[r] = wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Array update; register 0 is never written so it stays at its reset value of zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) r_rf[r] <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            if (w_wr_hit[r] && (r != ZERO_REG)) r_rf[r] <= w_wr_val[r];
         end
      end
   end

   regfile_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_iss_en   (iss_en),
      .i_iss_addr (iss_addr),
      .i_flush    (flush),
      .i_clr_vec  (w_wr_hit),
      .o_busy_vec (busy_vec)
   );

   // Read ports: zero register, then bypass from the highest-index matching writer, then array
   always_comb begin
      logic [AW-1:0]   v_a;
      logic            v_hit;
      logic [XLEN-1:0] v_d;
      rd_data  = '0;
      rd_ready = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         v_a   = rd_addr[i*AW +: AW];
         v_hit = 1'b0;
         v_d   = r_rf[v_a];
         for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == v_a)) begin
               v_hit = 1'b1;
               v_d   = wr_data[j*XLEN +: XLEN];
            end
         end
         if (v_a == AW'(ZERO_REG)) begin
            rd_data[i*XLEN +: XLEN] = '0;
            rd_ready[i]             = 1'b1;
         end else begin
            rd_data[i*XLEN +: XLEN] = v_d;
            rd_ready[i]             = ~busy_vec[v_a] | v_hit;
         end
      end
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with an integrated per-register scoreboard, successor to the single-write two-read register file in the decode stage. Provides `NRD` combinational read ports with same-cycle write bypass and `NWR` prioritised write ports. A pending-bit array lets the issue stage mark a destination busy and the writeback ports retire it. Sits between decode/issue (reads, issue marks) and writeback (writes, clears).

## Interface
- `XLEN`, 32, data width in bits
- `NREG`, 32, number of architectural registers; register 0 is hardwired zero; power of two ≥ 2
- `NRD`, 2, number of read ports
- `NWR`, 2, number of write ports
- `AW`, `$clog2(NREG)`, address width (derived, not overridden)

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `rd_addr`  in  `NRD*AW`  read addresses, port i at `[i*AW +: AW]`
- `rd_data`  out  `NRD*XLEN`  read data, port i at `[i*XLEN +: XLEN]`
- `rd_ready`  out  `NRD`  1 = `rd_data[i]` holds the committed or bypassed final value
- `wr_en`  in  `NWR`  write enables
- `wr_addr`  in  `NWR*AW`  write addresses
- `wr_data`  in  `NWR*XLEN`  write data
- `iss_en`  in  1  mark `iss_addr` pending
- `iss_addr`  in  `AW`  destination being issued
- `flush`  in  1  clear all pending bits
- `busy_vec`  out  `NREG`  current pending bits; bit 0 always 0

## Operation
- Array update: for each register r ≠ 0, on the clock edge take `wr_data` of the highest-index port j with `wr_en[j]` and `wr_addr[j]==r`. Otherwise hold.
- Writes to register 0 are discarded. Register 0 always reads 0, `rd_ready=1`.
- Read port i, address a ≠ 0:
  - If any enabled write port targets a, return the highest-index such port's `wr_data`.
  - Else return `rf[a]`.
- Pending bit r, next-state priority:
  1. `flush` → 0
  2. `iss_en && iss_addr==r` → 1
  3. any enabled write to r → 0
  4. hold
- Issue to register 0 is ignored.
- `rd_ready[i]` = (a==0) | ~pending[a] | (any enabled write to a this cycle).
- One outstanding producer per register: issue logic stalls while `busy_vec[r]`. The block does not count producers.

## Timing
- Reads and `rd_ready`: combinational, zero latency from `rd_addr`, `wr_*` and the pending state.
- Write: bypassed in the same cycle; visible from the array on the cycle after the edge.
- Issue mark: pending visible on `busy_vec`/`rd_ready` the cycle after `iss_en`.
- Same-cycle issue and write to the same r: r ends pending (the new producer wins).
- `flush` together with `iss_en`: all bits clear, including `iss_addr`.
- Reset (asynchronous, any cycle, including mid-write):
  - All registers are 0 and all pending bits are 0 immediately.
  - `busy_vec=0`; `rd_data` is 0 for every address unless bypassed; `rd_ready` is all 1.
  - Writes in the reset cycle are lost.

## Structure
- Package `regfile_pkg`: default `XLEN`/`NREG`, an `AW` helper function, and the `ZERO_REG` constant.
- Sub-module `regfile_scoreboard`:
  - Holds the `NREG` pending flops, the set/clear/flush priority and `busy_vec`.
  - Data array, write priority and bypass muxes stay in the top module.

## Test plan
- Reset, then read all 32 addresses on both ports → `rd_data=0`, `rd_ready=1`, `busy_vec=0`.
- Write port 0: r5 ← 0xDEADBEEF. Read r5 on port 1 in the same cycle → 0xDEADBEEF (bypass). Next cycle, array read → 0xDEADBEEF.
- Same cycle, both write ports target r7: port 0 ← 0x11, port 1 ← 0x22 → bypass and array both give 0x22.
- Write 0x55 to r0, and issue r0 → r0 reads 0, `busy_vec[0]=0`.
- Scoreboard sequence:
  - Issue r3 → next cycle `busy_vec[3]=1`, `rd_ready=0` for r3.
  - Write r3 ← 0x9 → `rd_ready=1` with data 0x9 in that cycle, and `busy_vec[3]=0` the next cycle.
  - Issue r3 and write r3 in the same cycle → stays busy.
- Issue r4 and r6, then assert `flush` with `iss_en` on r8 → `busy_vec=0`. Assert `rst` mid-cycle after writes → all state 0 immediately.
